expr_checker: RTL and testbench

EXPR_CHECKER -- requirements
Module: expr_checker

---
 rtl/expr_checker.sv | 110 +++++++++++
 tb/tb_expr_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_checker.sv
// Streaming syntax checker for arithmetic expressions of digits, operators and
// parentheses; one character per valid cycle, verdict registered one cycle later.
module expr_checker #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int EXT_OPS    = 0,
  parameter int CNT_W      = 8
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic [7:0]                       in,
  input  logic                             in_valid,
  output logic                             out,
  output logic                             err,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
  output logic [CNT_W-1:0]                 op_cnt
);

  localparam int DEP_W = $clog2(MAX_DEPTH + 1);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    EXP_OPND  = 2'd0,
    IN_NUM    = 2'd1,
    AFT_CLOSE = 2'd2,
    ERR       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DEP_W-1:0]   depth_q, depth_d;
  logic [DIG_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               err_q;

  logic is_digit, is_op, is_lp, is_rp;

  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2A) ||
               ((EXT_OPS != 0) && ((in == 8'h2D) || (in == 8'h2F)));
    is_lp    = (in == 8'h28);
    is_rp    = (in == 8'h29);
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EXP_OPND: begin
        if (is_digit) begin
          state_d = IN_NUM;
          dcnt_d  = DIG_W'(1);
        end else if (is_lp && (depth_q < DEP_W'(MAX_DEPTH))) begin
          depth_d = depth_q + 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      IN_NUM, AFT_CLOSE: begin
        if (is_digit && (state_q == IN_NUM)) begin
          if (dcnt_q < DIG_W'(MAX_DIGITS)) dcnt_d = dcnt_q + 1'b1;
          else                             state_d = ERR;
        end else if (is_op) begin
          state_d = EXP_OPND;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (is_rp && (depth_q != '0)) begin
          state_d = AFT_CLOSE;
          depth_d = depth_q - 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = ERR;
    endcase
    // Counters freeze on the transition into ERR, not just while in it.
    if (state_d == ERR) begin
      depth_d = depth_q;
      dcnt_d  = dcnt_q;
      cnt_d   = cnt_q;
    end
    out_d = ((state_d == IN_NUM) || (state_d == AFT_CLOSE)) && (depth_d == '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EXP_OPND;
      depth_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (in_valid) begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= (state_d == ERR);
    end
  end

  assign out    = out_q;
  assign err    = err_q;
  assign depth  = depth_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_expr_checker.sv
// Drives two differently-parameterised checkers with the same character stream and
// compares both against a token-level reference model every cycle.
module tb_expr_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in_ch = 8'h00;
  logic       in_valid = 1'b0;

  logic       out0, err0, out1, err1;
  logic [1:0] dep0, dep1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  expr_checker dut0 (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .out(out0), .err(err0), .depth(dep0), .op_cnt(cnt0)
  );

  expr_checker #(.MAX_DIGITS(3), .MAX_DEPTH(2), .EXT_OPS(1), .CNT_W(2)) dut1 (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .out(out1), .err(err1), .depth(dep1), .op_cnt(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what kind of token came last rather than FSM states.
  // last: 0 = expecting operand, 1 = inside number, 2 = after ')'.
  int  m_dig[2]    = '{4, 3};
  int  m_maxdep[2] = '{3, 2};
  int  m_ext[2]    = '{0, 1};
  int  m_cmax[2]   = '{255, 3};
  bit  m_live = 0;
  bit  m_err[2];
  int  m_dep[2], m_nd[2], m_last[2], m_cnt[2];
  bit  m_out[2];

  function automatic void model_step(input int k, input byte c);
    bit dig, op;
    if (m_err[k]) return;
    dig = (c >= "0") && (c <= "9");
    op  = (c == "+") || (c == "*") || (m_ext[k] != 0 && (c == "-" || c == "/"));
    if (dig) begin
      if (m_last[k] == 0)                          begin m_last[k] = 1; m_nd[k] = 1; end
      else if (m_last[k] == 1 && m_nd[k] < m_dig[k]) m_nd[k]++;
      else                                           m_err[k] = 1;
    end else if (op) begin
      if (m_last[k] != 0) begin
        m_last[k] = 0;
        if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
      end else m_err[k] = 1;
    end else if (c == "(") begin
      if (m_last[k] == 0 && m_dep[k] < m_maxdep[k]) m_dep[k]++;
      else m_err[k] = 1;
    end else if (c == ")") begin
      if (m_last[k] != 0 && m_dep[k] > 0) begin m_dep[k]--; m_last[k] = 2; end
      else m_err[k] = 1;
    end else m_err[k] = 1;
    m_out[k] = !m_err[k] && (m_last[k] != 0) && (m_dep[k] == 0);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_err[k] = 0; m_dep[k] = 0; m_nd[k] = 0; m_last[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
      end else if (in_valid && m_live) begin
        model_step(k, in_ch);
      end
    end
    if (clr) m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      cmp("out0",   int'(out0), int'(m_out[0]));
      cmp("err0",   int'(err0), int'(m_err[0]));
      cmp("depth0", int'(dep0), m_dep[0]);
      cmp("opcnt0", int'(cnt0), m_cnt[0]);
      cmp("out1",   int'(out1), int'(m_out[1]));
      cmp("err1",   int'(err1), int'(m_err[1]));
      cmp("depth1", int'(dep1), m_dep[1]);
      cmp("opcnt1", int'(cnt1), m_cnt[1]);
    end
  end

  task automatic send(input byte c);
    in_ch = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    string s;
    int    exp_dep[8] = '{1, 1, 1, 1, 2, 2, 1, 0};
    @(posedge clk); #1;
    idle(2);

    // Reset values; clr wins over a simultaneous valid character.
    in_ch = "("; in_valid = 1'b1;
    do_clr();
    cmp("rst_out0", int'(out0), 0);
    cmp("rst_err0", int'(err0), 0);
    cmp("rst_dep0", int'(dep0), 0);
    cmp("rst_cnt0", int'(cnt0), 0);

    // "1+2"
    send("1"); cmp("a_out1", int'(out0), 1);
    send("+"); cmp("a_out2", int'(out0), 0);
    send("2"); cmp("a_out3", int'(out0), 1);
    cmp("a_err", int'(err0), 0);
    cmp("a_cnt", int'(cnt0), 1);

    // Nested parens, depth limit 2 on dut1
    do_clr();
    s = "(12*(3))";
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      cmp("b_dep1", int'(dep1), exp_dep[i]);
      cmp("b_out1", int'(out1), (i == s.len() - 1) ? 1 : 0);
    end
    cmp("b_cnt1", int'(cnt1), 1);

    // Depth overflow on dut1 only
    do_clr();
    send("("); send("("); send("(");
    cmp("c_err1", int'(err1), 1);
    cmp("c_dep1", int'(dep1), 2);
    cmp("c_err0", int'(err0), 0);
    cmp("c_dep0", int'(dep0), 3);
    send("1"); send(")");
    cmp("c_err1b", int'(err1), 1);
    cmp("c_out1b", int'(out1), 0);

    // Digit limit 3 on dut1
    do_clr();
    send("1"); send("2"); send("3");
    cmp("d_out1", int'(out1), 1);
    send("4");
    cmp("d_err1", int'(err1), 1);
    cmp("d_out1b", int'(out1), 0);
    cmp("d_out0", int'(out0), 1);

    // '-' is OTHER on dut0, an operator on dut1
    do_clr();
    send("5"); send("-");
    cmp("e_err0", int'(err0), 1);
    cmp("e_out1m", int'(out1), 0);
    send("6");
    cmp("e_out1", int'(out1), 1);
    send("/"); send("8");
    cmp("e_cnt1", int'(cnt1), 2);

    // Gaps hold outputs; clr mid-expression
    do_clr();
    send("7"); idle(3);
    cmp("f_hold_out", int'(out0), 1);
    send("+"); idle(2);
    cmp("f_hold_cnt", int'(cnt0), 1);
    cmp("f_hold_out2", int'(out0), 0);
    do_clr();
    cmp("f_clr_cnt", int'(cnt0), 0);
    cmp("f_clr_err", int'(err0), 0);
    send("9");
    cmp("f_out", int'(out0), 1);

    // Operator counter saturation (dut1 CNT_W=2)
    do_clr();
    s = "1+1*1+1*1+1";
    for (int i = 0; i < s.len(); i++) send(s[i]);
    cmp("g_cnt0", int'(cnt0), 5);
    cmp("g_cnt1", int'(cnt1), 3);
    cmp("g_out1", int'(out1), 1);

    // Leading zeros, close-then-digit, stray ')', other char, clr out of ERR
    do_clr();
    send("0"); send("0"); send("7");
    cmp("h_out0", int'(out0), 1);
    do_clr();
    send("("); send("1"); send(")"); send("2");
    cmp("h_err_close_dig", int'(err0), 1);
    do_clr();
    send("1"); send(")");
    cmp("h_err_rp0", int'(err0), 1);
    do_clr();
    send(" ");
    cmp("h_err_other", int'(err0), 1);
    do_clr();
    send("(");
    send("("); send("4"); send(")"); send(")");
    cmp("h_out_after", int'(out0), 1);
    send("+"); send("+");
    cmp("h_cnt_frz", int'(cnt0), 1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
